// File: rtl/s_axi_lite_regs_if.sv
// AXI4-Lite bus bundle between a master and the s_axi_lite_regs register file.
// Latency: none; this is wiring only.
// Backpressure: carries the five valid/ready channel pairs (AW, W, B, AR, R).
// Ports: aw*/w*/ar* request channels and b*/r* response channels; modports
// master (drives requests, consumes responses) and slave (the reverse).
interface s_axi_lite_regs_if #(
  parameter int DWIDTH = 32
);
  logic              awvalid;
  logic [DWIDTH-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awready;
  logic              wvalid;
  logic [DWIDTH-1:0] wdata;
  logic [DWIDTH/8-1:0] wstrb;
  logic              wready;
  logic              bvalid;
  logic [1:0]        bresp;
  logic              bready;
  logic              arvalid;
  logic [DWIDTH-1:0] araddr;
  logic [2:0]        arprot;
  logic              arready;
  logic              rvalid;
  logic [DWIDTH-1:0] rdata;
  logic [1:0]        rresp;
  logic              rready;

  modport master (
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, bresp, output bready,
    output arvalid, araddr, arprot, input arready,
    input rvalid, rdata, rresp, output rready
  );

  modport slave (
    input awvalid, awaddr, awprot, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp, input rready
  );
endinterface

// File: rtl/s_axi_lite_regs.sv
// AXI4-Lite slave register file: REG_NUM x 32-bit registers, flat export, per-register write pulse.
// Latency: AW+W accepted on edge N -> B after edge N+1; AR accepted on edge N -> R after edge N.
// Backpressure: one-deep AW/W capture, at most one outstanding B and one outstanding R.
// Ports: clk, xrst (async active-low), s_axi (slave modport), reg_out (reg i at
// [DWIDTH*i +: DWIDTH]), wr_pulse (one cycle after register i is written).
module s_axi_lite_regs #(
  parameter int DWIDTH  = 32,
  parameter int REG_NUM = 4,
  parameter int IDX_BIT = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
) (
  input  logic                      clk,
  input  logic                      xrst,
  s_axi_lite_regs_if.slave          s_axi,
  output logic [DWIDTH*REG_NUM-1:0] reg_out,
  output logic [REG_NUM-1:0]        wr_pulse
);

  localparam int NBYTE = DWIDTH / 8;

  typedef logic [REG_NUM-1:0][DWIDTH-1:0] regs_t;

  logic               live_q, live_d;
  logic               aw_full_q, aw_full_d;
  logic [IDX_BIT-1:0] aw_idx_q, aw_idx_d;
  logic               w_full_q, w_full_d;
  logic [DWIDTH-1:0]  wdata_q, wdata_d;
  logic [NBYTE-1:0]   wstrb_q, wstrb_d;
  logic               bvalid_q, bvalid_d;
  logic [1:0]         bresp_q, bresp_d;
  regs_t              regs_q, regs_d;
  logic [REG_NUM-1:0] wr_pulse_q, wr_pulse_d;
  logic               rvalid_q, rvalid_d;
  logic [DWIDTH-1:0]  rdata_q, rdata_d;
  logic [1:0]         rresp_q, rresp_d;

  logic               awready, wready, arready;
  logic               aw_hs, w_hs, ar_hs, commit;
  logic [IDX_BIT-1:0] ar_idx;
  logic               aw_oor, ar_oor;
  logic               unused;

  function automatic logic idx_oor(input logic [IDX_BIT-1:0] idx);
    return 32'(idx) >= 32'(REG_NUM);
  endfunction

  // live_q holds the readies low while reset is asserted and releases them on
  // the first clock after reset goes away.
  assign awready = live_q && !aw_full_q;
  assign wready  = live_q && !w_full_q;
  assign arready = live_q && !rvalid_q;

  assign aw_hs  = s_axi.awvalid && awready;
  assign w_hs   = s_axi.wvalid && wready;
  assign ar_hs  = s_axi.arvalid && arready;
  // A new write commits only once the previous response has been taken.
  assign commit = aw_full_q && w_full_q && !bvalid_q;

  assign ar_idx = s_axi.araddr[IDX_BIT+1:2];
  assign aw_oor = idx_oor(aw_idx_q);
  assign ar_oor = idx_oor(ar_idx);

  // Address bits outside the index field alias by design; prot is not used.
  assign unused = ^{s_axi.awprot, s_axi.arprot,
                    s_axi.awaddr[1:0], s_axi.awaddr[DWIDTH-1:IDX_BIT+2],
                    s_axi.araddr[1:0], s_axi.araddr[DWIDTH-1:IDX_BIT+2]};

  always_comb begin
    live_d     = 1'b1;
    aw_full_d  = aw_full_q;
    aw_idx_d   = aw_idx_q;
    w_full_d   = w_full_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = s_axi.awaddr[IDX_BIT+1:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = s_axi.wdata;
      wstrb_d  = s_axi.wstrb;
    end

    if (bvalid_q && s_axi.bready) begin
      bvalid_d = 1'b0;
    end

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_oor ? 2'b10 : 2'b00;
      // Out-of-range indices match no register, so nothing is written or pulsed.
      for (int i = 0; i < REG_NUM; i++) begin
        if (aw_idx_q == IDX_BIT'(i)) begin
          wr_pulse_d[i] = 1'b1;
          for (int k = 0; k < NBYTE; k++) begin
            if (wstrb_q[k]) begin
              regs_d[i][8*k +: 8] = wdata_q[8*k +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    if (rvalid_q && s_axi.rready) begin
      rvalid_d = 1'b0;
      rdata_d  = '0;
      rresp_d  = 2'b00;
    end

    // Reads sample regs_q, so a same-edge commit is not yet visible.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = ar_oor ? 2'b10 : 2'b00;
      rdata_d  = '0;
      for (int i = 0; i < REG_NUM; i++) begin
        if (ar_idx == IDX_BIT'(i)) begin
          rdata_d = regs_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      live_q     <= 1'b0;
      aw_full_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_full_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      regs_q     <= '0;
      wr_pulse_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
    end else begin
      live_q     <= live_d;
      aw_full_q  <= aw_full_d;
      aw_idx_q   <= aw_idx_d;
      w_full_q   <= w_full_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign reg_out       = regs_q;
  assign wr_pulse      = wr_pulse_q;

endmodule

// File: tb/tb_s_axi_lite_regs.sv
// Directed bench for s_axi_lite_regs with REG_NUM=3 (so index 3 is out of range).
module tb_s_axi_lite_regs;

  localparam int RN = 3;

  logic            clk;
  logic            xrst;
  logic [32*RN-1:0] reg_out;
  logic [RN-1:0]   wr_pulse;

  int total;
  int bad;
  int b_hs_cnt;

  s_axi_lite_regs_if #(.DWIDTH(32)) axi ();

  s_axi_lite_regs #(.DWIDTH(32), .REG_NUM(RN)) dut (
    .clk      (clk),
    .xrst     (xrst),
    .s_axi    (axi),
    .reg_out  (reg_out),
    .wr_pulse (wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // B handshakes counted between edges, where bvalid/bready are stable.
  initial b_hs_cnt = 0;
  always @(negedge clk) if (axi.bvalid && axi.bready) b_hs_cnt = b_hs_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    logic [2:0]  pulse;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [2:0] pulses);
    int  n;
    logic aw_pend, w_pend, aw_r, w_r;
    axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b1;
    resp = 2'b00; pulses = '0;
    aw_pend = 1'b1; w_pend = 1'b1; n = 0;
    while ((aw_pend || w_pend) && n < 20) begin
      aw_r = axi.awready; w_r = axi.wready;
      tick(); n++;
      if (aw_pend && aw_r) begin aw_pend = 1'b0; axi.awvalid = 1'b0; end
      if (w_pend && w_r) begin w_pend = 1'b0; axi.wvalid = 1'b0; end
      pulses = pulses | wr_pulse;
    end
    check("write_accept_timeout", {94'd0, aw_pend, w_pend}, 96'd0);
    n = 0;
    while (!axi.bvalid && n < 20) begin
      tick(); n++;
      pulses = pulses | wr_pulse;
    end
    check("bvalid_timeout", {95'd0, axi.bvalid}, 96'd1);
    resp = axi.bresp;
    tick();
    pulses = pulses | wr_pulse;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int  n;
    logic ar_r, done;
    axi.araddr = a; axi.arvalid = 1'b1; axi.rready = 1'b1;
    done = 1'b0; n = 0;
    while (!done && n < 20) begin
      ar_r = axi.arready;
      tick(); n++;
      if (ar_r) begin done = 1'b1; axi.arvalid = 1'b0; end
    end
    check("read_accept_timeout", {95'd0, axi.rvalid}, 96'd1);
    d = axi.rdata; resp = axi.rresp;
    tick();
    axi.rready = 1'b0;
    axi.arvalid = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp, rresp;
    logic [2:0]  pulses;
    logic [31:0] rd;
    int          hs_base;

    total = 0; bad = 0;
    axi.awvalid = 0; axi.awaddr = 0; axi.awprot = 0;
    axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.bready = 0;
    axi.arvalid = 0; axi.araddr = 0; axi.arprot = 0; axi.rready = 0;
    xrst = 1'b0;

    vecs[0] = '{32'h0000_0000, 32'h1122_3344, 4'b0001, 2'b00, 3'b001, 32'h0000_0000, 32'h0000_0044, 2'b00};
    vecs[1] = '{32'h0000_0004, 32'h5566_7788, 4'b1000, 2'b00, 3'b010, 32'h0000_0004, 32'h55FE_F00D, 2'b00};
    vecs[2] = '{32'h0000_0008, 32'hFFFF_FFFF, 4'b0000, 2'b00, 3'b100, 32'h0000_0008, 32'h0BAD_C0DE, 2'b00};
    vecs[3] = '{32'h0000_001C, 32'h0000_0001, 4'b1111, 2'b10, 3'b000, 32'h0000_001C, 32'h0000_0000, 2'b10};
    vecs[4] = '{32'hFFFF_FFF5, 32'h0000_ABCD, 4'b0110, 2'b00, 3'b010, 32'h0000_0004, 32'h5500_AB0D, 2'b00};
    vecs[5] = '{32'h0000_0002, 32'hA5A5_A5A5, 4'b1100, 2'b00, 3'b001, 32'h0000_0040, 32'hA5A5_0044, 2'b00};

    // Reset state: everything low, including readies.
    tick(); tick();
    check("rst_awready", {95'd0, axi.awready}, 96'd0);
    check("rst_wready",  {95'd0, axi.wready},  96'd0);
    check("rst_arready", {95'd0, axi.arready}, 96'd0);
    check("rst_bvalid",  {95'd0, axi.bvalid},  96'd0);
    check("rst_rvalid",  {95'd0, axi.rvalid},  96'd0);
    check("rst_rdata",   {64'd0, axi.rdata},   96'd0);
    check("rst_reg_out", reg_out, 96'd0);
    check("rst_wr_pulse", {93'd0, wr_pulse}, 96'd0);
    xrst = 1'b1;
    tick();
    check("post_rst_readies", {93'd0, axi.awready, axi.wready, axi.arready}, 96'b111);

    // Same-cycle AW+W to reg1.
    axi.bready = 1'b1;
    axi.awaddr = 32'h4; axi.wdata = 32'hDEADBEEF; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    check("t1_readies_drop", {94'd0, axi.awready, axi.wready}, 96'd0);
    check("t1_no_b_yet", {95'd0, axi.bvalid}, 96'd0);
    tick();
    check("t1_bvalid_bresp", {93'd0, axi.bvalid, axi.bresp}, {93'd0, 1'b1, 2'b00});
    check("t1_reg1", {64'd0, reg_out[63:32]}, 96'hDEADBEEF);
    check("t1_pulse", {93'd0, wr_pulse}, 96'b010);
    tick();
    check("t1_b_done", {95'd0, axi.bvalid}, 96'd0);
    check("t1_pulse_gone", {93'd0, wr_pulse}, 96'd0);

    // W three cycles ahead of AW, partial strobe over a preset value.
    do_write(32'h8, 32'hAAAAAAAA, 4'hF, resp, pulses);
    check("t2_preset_reg2", {64'd0, reg_out[95:64]}, 96'hAAAAAAAA);
    axi.wdata = 32'h12345678; axi.wstrb = 4'b0011; axi.wvalid = 1'b1;
    tick();
    axi.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_wready_low", {94'd0, axi.wready, axi.bvalid}, 96'd0);
      tick();
    end
    axi.awaddr = 32'h8; axi.awvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    tick();
    check("t2_bvalid_bresp", {93'd0, axi.bvalid, axi.bresp}, {93'd0, 1'b1, 2'b00});
    check("t2_reg2", {64'd0, reg_out[95:64]}, 96'hAAAA5678);
    tick();

    // Out-of-range write and read.
    do_write(32'hC, 32'h99999999, 4'hF, resp, pulses);
    check("t3_bresp", {94'd0, resp}, 96'b10);
    check("t3_no_pulse", {93'd0, pulses}, 96'd0);
    check("t3_regs_unchanged", reg_out, 96'hAAAA5678_DEADBEEF_00000000);
    do_read(32'hC, rd, rresp);
    check("t3_rresp", {94'd0, rresp}, 96'b10);
    check("t3_rdata", {64'd0, rd}, 96'd0);

    // Aliased write to reg0, read held off by rready.
    do_write(32'h1111_1111, 32'h5, 4'hF, resp, pulses);
    check("t4_bresp", {94'd0, resp}, 96'd0);
    check("t4_pulse", {93'd0, pulses}, 96'b001);
    axi.rready = 1'b0; axi.araddr = 32'h1111_1111; axi.arvalid = 1'b1;
    tick();
    axi.arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t4_r_held", {62'd0, axi.rvalid, axi.arready, axi.rdata}, {62'd0, 1'b1, 1'b0, 32'h5});
      tick();
    end
    axi.rready = 1'b1;
    tick();
    check("t4_r_done", {63'd0, axi.rvalid, axi.rdata}, 96'd0);
    axi.rready = 1'b0;

    // Second write captured while the first response is stalled.
    hs_base = b_hs_cnt;
    axi.bready = 1'b0;
    axi.awaddr = 32'h4; axi.wdata = 32'hCAFEF00D; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    tick();
    check("t5_first_b", {93'd0, axi.bvalid, axi.bresp}, {93'd0, 1'b1, 2'b00});
    check("t5_reg1", {64'd0, reg_out[63:32]}, 96'hCAFEF00D);
    axi.awaddr = 32'h8; axi.wdata = 32'h0BADC0DE;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    check("t5_second_captured", {94'd0, axi.awready, axi.wready}, 96'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_b_stable", {93'd0, axi.bvalid, axi.bresp}, {93'd0, 1'b1, 2'b00});
      check("t5_reg2_waiting", {64'd0, reg_out[95:64]}, 96'hAAAA5678);
    end
    axi.bready = 1'b1;
    tick();
    check("t5_b1_taken", {95'd0, axi.bvalid}, 96'd0);
    check("t5_reg2_not_yet", {64'd0, reg_out[95:64]}, 96'hAAAA5678);
    tick();
    check("t5_second_b", {95'd0, axi.bvalid}, 96'd1);
    check("t5_reg2", {64'd0, reg_out[95:64]}, 96'h0BADC0DE);
    check("t5_pulse2", {93'd0, wr_pulse}, 96'b100);
    tick();
    check("t5_b2_taken", {95'd0, axi.bvalid}, 96'd0);
    check("t5_hs_count", 96'(b_hs_cnt - hs_base), 96'd2);

    // Table of write-then-read vectors.
    for (int v = 0; v < 6; v++) begin
      do_write(vecs[v].waddr, vecs[v].wdata, vecs[v].wstrb, resp, pulses);
      check($sformatf("vec%0d_bresp", v), {94'd0, resp}, {94'd0, vecs[v].bresp});
      check($sformatf("vec%0d_pulse", v), {93'd0, pulses}, {93'd0, vecs[v].pulse});
      do_read(vecs[v].raddr, rd, rresp);
      check($sformatf("vec%0d_rdata", v), {64'd0, rd}, {64'd0, vecs[v].rdata});
      check($sformatf("vec%0d_rresp", v), {94'd0, rresp}, {94'd0, vecs[v].rresp});
    end

    // Read accepted on the commit edge returns the old value.
    axi.bready = 1'b1; axi.rready = 1'b0;
    axi.awaddr = 32'h8; axi.wdata = 32'h13572468; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    axi.araddr = 32'h8; axi.arvalid = 1'b1;
    tick();
    axi.arvalid = 1'b0;
    check("rw_old_value", {63'd0, axi.rvalid, axi.rdata}, {63'd0, 1'b1, 32'h0BADC0DE});
    check("rw_reg2_new", {64'd0, reg_out[95:64]}, 96'h13572468);
    check("rw_bvalid", {95'd0, axi.bvalid}, 96'd1);
    axi.rready = 1'b1;
    tick();
    check("rw_r_done", {63'd0, axi.rvalid, axi.rdata}, 96'd0);
    axi.rready = 1'b0;

    // Reset with AW captured and W missing.
    axi.awaddr = 32'h0; axi.awvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    check("t6_aw_full", {94'd0, axi.awready, axi.wready}, 96'b01);
    xrst = 1'b0;
    #1;
    check("t6_rst_outputs", {90'd0, axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid, |wr_pulse}, 96'd0);
    check("t6_rst_regs", reg_out, 96'd0);
    tick();
    xrst = 1'b1;
    tick();
    check("t6_readies", {94'd0, axi.awready, axi.wready}, 96'b11);
    axi.wdata = 32'h77; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    tick();
    axi.wvalid = 1'b0;
    check("t6_w_captured", {95'd0, axi.wready}, 96'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_bvalid", {95'd0, axi.bvalid}, 96'd0);
    end
    check("t6_regs_zero", reg_out, 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/s_axi_lite_regs.md
Name: s_axi_lite_regs

Overview:
AXI4-Lite slave register file that terminates the AXI-Lite master port of the test/traffic stage. It accepts single-beat writes and reads into REG_NUM 32-bit registers. The registers are exposed flat to user logic, with a per-register write pulse. Out-of-range accesses complete with SLVERR so the upstream master's error flags can be exercised.

Parameters:
DWIDTH, 32, data/address width (only 32 supported; wstrb is DWIDTH/8)
REG_NUM, 4, number of registers (1..16)
IDX_BIT, clogb2(REG_NUM) (minimum 1), register index width

Ports:
clk  in  1  clock
xrst  in  1  asynchronous active-low reset
awvalid  in  1  write address valid
awaddr  in  DWIDTH  write address
awprot  in  3  ignored
awready  out  1  write address ready
wvalid  in  1  write data valid
wdata  in  DWIDTH  write data
wstrb  in  DWIDTH/8  byte strobes
wready  out  1  write data ready
bvalid  out  1  write response valid
bresp  out  2  write response (00 OKAY, 10 SLVERR)
bready  in  1  write response ready
arvalid  in  1  read address valid
araddr  in  DWIDTH  read address
arprot  in  3  ignored
arready  out  1  read address ready
rvalid  out  1  read data valid
rdata  out  DWIDTH  read data
rresp  out  2  read response
rready  in  1  read data ready
reg_out  out  DWIDTH*REG_NUM  register contents, reg i at bits [DWIDTH*i +: DWIDTH]
wr_pulse  out  REG_NUM  one-cycle pulse on the cycle after register i is written

Behaviour:
- Reset: xrst low asynchronously clears all state. All outputs are 0: awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, wr_pulse, and every register.
- Reset mid-transaction drops any latched address/data and any pending response; no write commits.
- Address decode:
  - idx = addr[IDX_BIT+1:2]; addr[1:0] and bits above IDX_BIT+1 are ignored, so higher bits alias.
  - Out of range when idx >= REG_NUM.
- Write path: independent AW and W capture registers, aw_full and w_full.
  - awready = !aw_full; wready = !w_full. Both are combinational from state regs, not from valid inputs.
  - AW handshake (awvalid && awready) latches idx and sets aw_full.
  - W handshake latches wdata/wstrb and sets w_full.
  - AW and W may arrive in the same cycle or in either order with any gap.
- Commit: on the first edge where aw_full && w_full && !bvalid:
  - In-range: each byte k of reg[idx] with wstrb[k]=1 takes wdata byte k; wr_pulse[idx]=1 for exactly that following cycle; bresp=00.
  - Out of range: no register changes, no pulse, bresp=10.
  - bvalid<=1; aw_full and w_full clear.
- Latency: AW and W accepted on the same edge N -> bvalid high after edge N+1.
- bvalid holds, with bresp stable, until bvalid && bready, then clears on that edge.
- Back-to-back: a new AW/W may be captured while bvalid is pending (fulls already cleared). The commit waits until bvalid clears, so at most one outstanding response.
- Read path:
  - arready = !rvalid.
  - On AR handshake at edge N: rvalid=1, rdata=reg[idx] (0 if out of range), rresp=00/10, all visible after N.
  - rvalid/rdata/rresp hold until rvalid && rready; rdata returns to 0 on that edge.
- Read/write interaction: a read accepted on the same edge as a commit to the same register returns the pre-write value.
- Write and read channels are fully concurrent; there is no arbitration.
- wstrb=0 in range: OKAY response, no register change, wr_pulse still fires.

Test Plan:
- AW 0x0000_0004 and W 0xDEADBEEF/1111 in the same cycle, bready tied 1 -> awready/wready drop next cycle; bvalid=1 bresp=00 one cycle later; reg_out[63:32]=0xDEADBEEF; wr_pulse=0010 for one cycle.
- W 0x12345678/0011 three cycles before AW 0x0000_0008, reg2 preset 0xAAAAAAAA -> wready low while waiting; reg2=0xAAAA5678 after commit; bresp=00.
- REG_NUM=3: write 0x0000_000C, then read 0x0000_000C -> bresp=10, no register change, no pulse; rresp=10, rdata=0.
- Write 0x5 to 0x1111_1111 (idx 0 via aliasing), read 0x1111_1111 with rready delayed 4 cycles -> rvalid held 4+ cycles with rdata=0x5; arready low throughout; rvalid clears on the rready edge.
- bready low for 5 cycles after the first write while a second AW/W is presented -> second AW/W captured; bvalid/bresp stable; second commit only after the first B handshake; two B handshakes total.
- xrst pulsed low with aw_full=1 and w_full=0 -> immediately all outputs 0 and awready=wready=1 after release; the later W alone produces no bvalid.
